// File: rtl/cache_dre_ri_ctrl.sv
// cache_dre_ri_ctrl: ri-side maintenance controller for the cache DRE store (clear sweep, refill mark, eviction query)
// Ports: flush_req/flush_ack - full clear handshake; fill_req/fill_line/fill_ch/fill_ack - mark line 8'hFF;
//   evict_req/evict_line/evict_ch/evict_valid/evict_re - read back a line's DRE byte;
//   busy/sel - controller owns the store; ri_read*/ri_write* - DRE store ri-side port.
// Build option: DRE_CLR_ON_RESET_EN makes the controller start a full clear sweep straight out of reset.
module cache_dre_ri_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  flush_ack,
  input  logic                  fill_req,
  input  logic [ADDR_WIDTH-2:0] fill_line,
  input  logic [1:0]            fill_ch,
  output logic                  fill_ack,
  input  logic                  evict_req,
  input  logic [ADDR_WIDTH-2:0] evict_line,
  input  logic [1:0]            evict_ch,
  output logic                  evict_valid,
  output logic [7:0]            evict_re,
  output logic                  busy,
  output logic                  sel,
  output logic [ADDR_WIDTH:0]   ri_readAddress,
  output logic [1:0]            ri_readChannel,
  input  logic [7:0]            ri_readData,
  output logic [ADDR_WIDTH-1:0] ri_writeAddress,
  output logic [1:0]            ri_writeChannel,
  output logic                  ri_writeEnable,
  output logic [7:0]            ri_writeData
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] EV_RD  = 3'd3;
  localparam logic [2:0] EV_CAP = 3'd4;
`ifdef DRE_CLR_ON_RESET_EN
  localparam logic [2:0] RST_STATE = CLEAR;
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam logic [2:0] RST_STATE = IDLE;
  localparam logic       RST_BUSY  = 1'b0;
`endif
  logic [2:0]            state, stateNext;
  logic [ADDR_WIDTH:0]   cnt, cntNext;
  logic [ADDR_WIDTH-2:0] capLine, lineNext;
  logic [1:0]            capCh, chNext;
  // cnt always holds the index of the clear write currently on the port
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    lineNext  = capLine;
    chNext    = capCh;
    case (state)
      IDLE: begin
        if (flush_req) begin
          stateNext = CLEAR;
        end else if (fill_req) begin
          stateNext = FILL;
          lineNext  = fill_line;
          chNext    = fill_ch;
        end else if (evict_req) begin
          stateNext = EV_RD;
          lineNext  = evict_line;
          chNext    = evict_ch;
        end
      end
      CLEAR: begin
        stateNext = &cnt ? IDLE : CLEAR;
        cntNext   = cnt + 1'b1;
      end
      EV_RD:   stateNext = EV_CAP;
      default: stateNext = IDLE;
    endcase
  end
  // all port outputs are registered from the next-state values so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RST_STATE;
      cnt             <= '0;
      capLine         <= '0;
      capCh           <= '0;
      busy            <= RST_BUSY;
      ri_writeEnable  <= RST_BUSY;
      ri_writeAddress <= '0;
      ri_writeChannel <= '0;
      ri_writeData    <= '0;
      ri_readAddress  <= '0;
      ri_readChannel  <= '0;
      flush_ack       <= 1'b0;
      fill_ack        <= 1'b0;
      evict_valid     <= 1'b0;
      evict_re        <= '0;
    end else begin
      state           <= stateNext;
      cnt             <= cntNext;
      capLine         <= lineNext;
      capCh           <= chNext;
      busy            <= stateNext != IDLE;
      ri_writeEnable  <= stateNext == CLEAR || stateNext == FILL;
      ri_writeAddress <= stateNext == CLEAR ? {cntNext[ADDR_WIDTH:2], 1'b0} : {lineNext, 1'b0};
      ri_writeChannel <= stateNext == CLEAR ? cntNext[1:0] : chNext;
      ri_writeData    <= stateNext == FILL ? 8'hFF : 8'h00;
      ri_readAddress  <= {lineNext, 2'b00};
      ri_readChannel  <= chNext;
      flush_ack       <= stateNext == CLEAR && &cntNext;
      fill_ack        <= stateNext == FILL;
      evict_valid     <= state == EV_CAP;
      if (state == EV_CAP) evict_re <= ri_readData;
    end
  end
  assign sel = busy;
endmodule

// File: tb/tb_cache_dre_ri_ctrl.sv
// tb_cache_dre_ri_ctrl: directed plus random checks of the DRE ri controller against a line-level store model
module tb_cache_dre_ri_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_req = 1'b0, fill_req = 1'b0, evict_req = 1'b0;
  logic [2:0] fill_line = '0, evict_line = '0;
  logic [1:0] fill_ch = '0, evict_ch = '0;
  logic       flush_ack, fill_ack, evict_valid, busy, sel, ri_writeEnable;
  logic [7:0] evict_re, ri_readData, ri_writeData;
  logic [4:0] ri_readAddress;
  logic [3:0] ri_writeAddress;
  logic [1:0] ri_readChannel, ri_writeChannel;
  logic [7:0] mem [32];
  logic [7:0] refMem [32];
  int vectors = 0;
  int miscompares = 0;
  cache_dre_ri_ctrl #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .fill_req(fill_req), .fill_line(fill_line), .fill_ch(fill_ch), .fill_ack(fill_ack),
    .evict_req(evict_req), .evict_line(evict_line), .evict_ch(evict_ch),
    .evict_valid(evict_valid), .evict_re(evict_re),
    .busy(busy), .sel(sel),
    .ri_readAddress(ri_readAddress), .ri_readChannel(ri_readChannel), .ri_readData(ri_readData),
    .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
    .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData)
  );
  always #5 clk = ~clk;
  // DRE store: synchronous write, registered read (data one cycle after address)
  always @(posedge clk) begin
    if (ri_writeEnable) mem[{ri_writeAddress[3:1], ri_writeChannel}] <= ri_writeData;
    ri_readData <= mem[{ri_readAddress[4:2], ri_readChannel}];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic doFlush();
    flush_req = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("clear_write", {busy, ri_writeEnable, ri_writeAddress, ri_writeChannel, ri_writeData, flush_ack},
          {1'b1, 1'b1, 3'(k / 4), 1'b0, 2'(k % 4), 8'h00, k == 31});
      if (k == 31) flush_req = 1'b0;
    end
    @(negedge clk);
    chk("clear_done", {busy, sel, ri_writeEnable, flush_ack}, 4'b0000);
    for (int i = 0; i < 32; i++) refMem[i] = 8'h00;
  endtask
  task automatic doFill(input int line, input int ch);
    fill_req = 1'b1;
    fill_line = 3'(line);
    fill_ch = 2'(ch);
    @(negedge clk);
    chk("fill_write", {busy, ri_writeEnable, ri_writeAddress, ri_writeChannel, ri_writeData, fill_ack},
        {1'b1, 1'b1, 3'(line), 1'b0, 2'(ch), 8'hFF, 1'b1});
    fill_req = 1'b0;
    fill_line = 3'($urandom);
    @(negedge clk);
    chk("fill_done", {busy, ri_writeEnable, fill_ack}, 3'b000);
    refMem[line * 4 + ch] = 8'hFF;
  endtask
  task automatic doEvict(input int line, input int ch);
    evict_req = 1'b1;
    evict_line = 3'(line);
    evict_ch = 2'(ch);
    @(negedge clk);
    chk("ev_rd", {busy, ri_writeEnable, evict_valid, ri_readAddress, ri_readChannel},
        {1'b1, 1'b0, 1'b0, 3'(line), 2'b00, 2'(ch)});
    evict_line = 3'($urandom);
    evict_ch = 2'($urandom);
    @(negedge clk);
    chk("ev_cap", {busy, ri_writeEnable, evict_valid, ri_readAddress, ri_readChannel},
        {1'b1, 1'b0, 1'b0, 3'(line), 2'b00, 2'(ch)});
    @(negedge clk);
    chk("ev_valid", {evict_valid, busy, evict_re}, {1'b1, 1'b0, refMem[line * 4 + ch]});
    evict_req = 1'b0;
    @(negedge clk);
    chk("ev_hold", {evict_valid, evict_re}, {1'b0, refMem[line * 4 + ch]});
  endtask
  initial begin
    int flushN, fillN, evN, flushAt, fillAt, evAt;
    logic [7:0] evByte;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, sel, ri_writeEnable, flush_ack, fill_ack, evict_valid, evict_re}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, sel, ri_writeEnable}, 3'b000);
    doFlush();
    doFill(5, 2);
    doFill(3, 1);
    doEvict(3, 1);
    doEvict(4, 1);
    // simultaneous requests: flush first, then fill, then evict, each exactly once
    flush_req = 1'b1;
    fill_req = 1'b1;
    fill_line = 3'd6;
    fill_ch = 2'd0;
    evict_req = 1'b1;
    evict_line = 3'd6;
    evict_ch = 2'd0;
    flushN = 0; fillN = 0; evN = 0; flushAt = -1; fillAt = -1; evAt = -1; evByte = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (flush_ack) begin flushN++; flushAt = c; flush_req = 1'b0; end
      if (fill_ack) begin fillN++; fillAt = c; fill_req = 1'b0; end
      if (evict_valid) begin evN++; evAt = c; evByte = evict_re; evict_req = 1'b0; end
    end
    chk("combo_counts", {8'(flushN), 8'(fillN), 8'(evN)}, {8'd1, 8'd1, 8'd1});
    chk("combo_order", {8'(flushAt), 8'(fillAt), 8'(evAt)}, {8'd31, 8'd33, 8'd37});
    chk("combo_evict_re", evByte, 8'hFF);
    for (int i = 0; i < 32; i++) refMem[i] = 8'h00;
    refMem[24] = 8'hFF;
    // async reset at cnt=10 of a sweep: entries 0..9 cleared, the rest untouched
    doFill(2, 1);
    doFill(2, 2);
    flush_req = 1'b1;
    for (int k = 0; k <= 10; k++) @(negedge clk);
    chk("pre_abort_cnt", {busy, ri_writeAddress, ri_writeChannel}, {1'b1, 3'd2, 1'b0, 2'd2});
    rst = 1'b1;
    flush_req = 1'b0;
    #1;
    chk("abort_outputs", {busy, sel, ri_writeEnable, flush_ack, fill_ack, evict_valid}, 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    flushN = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (flush_ack || busy) flushN++;
    end
    chk("abort_no_ack", flushN, 0);
    for (int i = 0; i < 10; i++) refMem[i] = 8'h00;
    doEvict(2, 1);
    doEvict(2, 2);
    doEvict(6, 0);
    // random mix against the line-level model
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) doFlush();
      else if (r < 5) doFill($urandom_range(0, 7), $urandom_range(0, 3));
      else doEvict($urandom_range(0, 7), $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_dre_ri_ctrl.md
Name: cache_dre_ri_ctrl

Overview:
- Maintenance controller that owns the ri-side of the cache byte-readable-enable (DRE) store and drives its sel line.
- Clears the whole DRE store after reset or flush.
- Marks a line fully readable (8'hFF) when a refill completes.
- Reads back a line's DRE byte for the eviction/write-back path.

Parameters:
ADDR_WIDTH, 8, DRE write-address width; line index is ADDR_WIDTH-1 bits (2**(ADDR_WIDTH-1) rows x 4 channels)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
flush_req  input  1  request full clear; level, held until flush_ack
flush_ack  output  1  one-cycle pulse when clear sweep completes
fill_req  input  1  refill complete; level, held until fill_ack
fill_line  input  ADDR_WIDTH-1  line index of refilled line
fill_ch  input  2  way of refilled line
fill_ack  output  1  one-cycle pulse in cycle the FF write is issued
evict_req  input  1  DRE query request; level, held until evict_valid
evict_line  input  ADDR_WIDTH-1  line index to query
evict_ch  input  2  way to query
evict_valid  output  1  one-cycle pulse, evict_re valid
evict_re  output  8  DRE byte of queried line, held until next query
busy  output  1  controller owns DRE store (sel high)
sel  output  1  DRE store mux select, 1 = ri side
ri_readAddress  output  ADDR_WIDTH+1  {line,2'b00}
ri_readChannel  output  2  query way
ri_readData  input  8  DRE byte, one cycle after address
ri_writeAddress  output  ADDR_WIDTH  {line,1'b0}
ri_writeChannel  output  2  write way
ri_writeEnable  output  1  write strobe
ri_writeData  output  8  8'h00 clear, 8'hFF fill

Behaviour:
- Reset values: state IDLE (CLEAR if DRE_CLR_ON_RESET_EN), all outputs 0, sweep counter 0, evict_re 8'h00.
- sel = busy = (state != IDLE), registered from next state.
- ri_* outputs are registered. In IDLE, ri_writeEnable = 0; the address/data outputs are don't-care.
- Arbitration in IDLE, fixed priority: flush > fill > evict. A request is sampled only in IDLE.
- CLEAR:
  - Counter cnt of ADDR_WIDTH+1 bits; ri_writeChannel = cnt[1:0], line = cnt[ADDR_WIDTH:2].
  - ri_writeData = 8'h00, ri_writeEnable = 1 each cycle.
  - Takes exactly 2**(ADDR_WIDTH+1) write cycles. On the last write (cnt all ones): flush_ack pulses, cnt wraps to 0, next state IDLE.
  - fill_req and evict_req are ignored (not acked) during CLEAR.
- FILL:
  - One cycle with ri_writeEnable = 1, data 8'hFF, captured fill_line/fill_ch; fill_ack pulses in the same cycle.
  - Then IDLE, which guarantees at least one non-write cycle before any following query.
- EV_RD: drive ri_readAddress/ri_readChannel from captured evict_line/evict_ch for one cycle.
- EV_CAP:
  - Address held; ri_readData registered into evict_re; evict_valid pulses in the cycle after EV_CAP.
  - Then IDLE. Total query latency is 3 cycles from accept.
- Captured line/ch registers are loaded on accept. Later changes on request inputs do not affect an operation in progress.
- flush_req still asserted in the cycle after flush_ack starts a new sweep. Requesters must drop the request on ack.
- Async reset mid-sweep or mid-query:
  - Immediate return to reset state; partial clear is not completed.
  - No ack or evict_valid is issued for the aborted operation.
- ri_writeEnable never asserts in EV_RD/EV_CAP. ri_readAddress is don't-care outside them.

Optional Feature:
- DRE_CLR_ON_RESET_EN defined: reset state is CLEAR, so a full sweep starts automatically on rst deassert.
  - flush_ack pulses at sweep end as for a requested flush.
  - busy is 1 from reset.
- Not defined: reset state is IDLE and busy = 0 after reset. Software/cache must issue flush_req before first use; DRE contents are undefined until then.

Test Plan:
- ADDR_WIDTH=4, feature off, flush_req=1 -> busy next cycle; 32 writes of 8'h00 covering ch 0..3 x lines 0..7 in cnt order; flush_ack on 32nd write; IDLE after.
- fill_req with line=5, ch=2 in IDLE -> single write: addr 4'b1010, ch 2, data 8'hFF; fill_ack same cycle; busy back to 0 next cycle.
- Fill line 3 ch 1, then evict_req line 3 ch 1 with RAM model -> evict_re = 8'hFF, evict_valid 3 cycles after accept; a query of cleared line 4 ch 1 returns 8'h00.
- flush_req, fill_req, evict_req asserted together -> CLEAR first; fill served after flush_ack, then evict; no request lost or double-acked.
- rst pulsed at cnt=10 of a sweep -> all outputs 0 immediately, no flush_ack; with DRE_CLR_ON_RESET_EN a fresh sweep starts from cnt 0 on deassert.
- DRE_CLR_ON_RESET_EN defined, no requests -> busy=1 from reset, 32 clear writes, flush_ack pulse, then idle.
